// File: rtl/approx_mul_pkg.sv
// Shared FSM encoding and default parameters for the approximate sequential multiplier.
package approx_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_TRUNC = 3;
  localparam int DEF_ET    = 5;
  localparam int DEF_CW    = 8;

endpackage

// File: rtl/approx_pp_row.sv
// One partial-product row (a & b_bit) << idx, with columns below TRUNC dropped when approx=1.
// Purely combinational; no handshake.
module approx_pp_row #(
  parameter int WIDTH = 4,
  parameter int TRUNC = 3,
  parameter int IW    = 2
) (
  input  logic [WIDTH-1:0]   a,
  input  logic               b_bit,
  input  logic [IW-1:0]      idx,
  input  logic               approx,
  output logic [2*WIDTH-1:0] row
);

  logic [WIDTH-1:0] masked;

  always_comb begin
    masked = '0;
    for (int j = 0; j < WIDTH; j++) begin
      masked[j] = a[j] & b_bit;
      // Bit lands in column idx+j; drop it when that column is truncated.
      if (approx && ((int'(idx) + j) < TRUNC)) begin
        masked[j] = 1'b0;
      end
    end
  end

  assign row = {{WIDTH{1'b0}}, masked} << idx;

endmodule

// File: rtl/approx_mul_seq.sv
// Shift-add multiplier with optional truncated mode; result valid WIDTH edges after accept.
// Single operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module approx_mul_seq
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TRUNC = DEF_TRUNC,
  parameter int ET    = DEF_ET,
  parameter int CW    = DEF_CW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               err_flag,
  output logic [CW-1:0]      viol_count,
  input  logic               count_clr
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(WIDTH);
  localparam logic [PW-1:0] ET_V    = PW'(ET);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic            approx_r;
  logic [SW-1:0]   step;
  logic [PW-1:0]   exact_acc, approx_acc;
  logic [PW-1:0]   row_exact, row_approx;
  logic [PW-1:0]   diff;
  logic            last_step;
  logic            accept, deliver;

  assign last_step = (step == SW'(WIDTH - 1));
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  approx_pp_row #(.WIDTH(WIDTH), .TRUNC(TRUNC), .IW(SW)) u_row_exact (
    .a      (a_r),
    .b_bit  (b_r[step]),
    .idx    (step),
    .approx (1'b0),
    .row    (row_exact)
  );

  approx_pp_row #(.WIDTH(WIDTH), .TRUNC(TRUNC), .IW(SW)) u_row_approx (
    .a      (a_r),
    .b_bit  (b_r[step]),
    .idx    (step),
    .approx (approx_r),
    .row    (row_approx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r        <= '0;
      b_r        <= '0;
      approx_r   <= 1'b0;
      step       <= '0;
      exact_acc  <= '0;
      approx_acc <= '0;
    end else if (accept) begin
      a_r        <= a;
      b_r        <= b;
      approx_r   <= approx;
      step       <= '0;
      exact_acc  <= '0;
      approx_acc <= '0;
    end else if (state == RUN) begin
      exact_acc  <= exact_acc + row_exact;
      approx_acc <= approx_acc + row_approx;
      step       <= step + 1'b1;
    end
  end

  // Truncation only removes bits, so the approximate sum never exceeds the exact one.
  assign diff     = exact_acc - approx_acc;
  assign product  = approx_acc;
  assign err_flag = (diff > ET_V);

  always_ff @(posedge clk) begin
    if (rst || count_clr) begin
      viol_count <= '0;
    end else if (deliver && err_flag && (viol_count != CNT_MAX)) begin
      viol_count <= viol_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_approx_mul_seq.sv
// Randomized self-checking bench for approx_mul_seq against an arithmetic reference model.
module tb_approx_mul_seq;

  localparam int W  = 4;
  localparam int TR = 3;
  localparam int ET = 5;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    a = '0;
  logic [W-1:0]    b = '0;
  logic            approx = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*W-1:0]  product;
  logic            err_flag;
  logic [CW-1:0]   viol_count;
  logic            count_clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;

  approx_mul_seq #(.WIDTH(W), .TRUNC(TR), .ET(ET), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .approx     (approx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .err_flag   (err_flag),
    .viol_count (viol_count),
    .count_clr  (count_clr)
  );

  always #5 clk = ~clk;

  // Sum every bit product a[j]*b[i] at weight 2^(i+j), skipping columns below TR in approx mode.
  function automatic int model_prod(input int av, input int bv, input bit ap);
    int s = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (((av >> j) & 1) == 1 && ((bv >> i) & 1) == 1 && !(ap && (i + j) < TR))
          s += (1 << (i + j));
    return s;
  endfunction

  function automatic bit model_err(input int av, input int bv, input bit ap);
    return ((av * bv) - model_prod(av, bv, ap)) > ET;
  endfunction

  function automatic int model_count(input int cnt, input bit ef, input bit clr);
    if (clr) return 0;
    if (ef && cnt < (1 << CW) - 1) return cnt + 1;
    return cnt;
  endfunction

  // Presents one operation and waits for out_valid; lat counts edges from accept to out_valid.
  task automatic do_op(input int av, input int bv, input bit ap,
                       output int lat, output logic [2*W-1:0] prod, output logic ef);
    int guard = 0;
    in_valid = 1'b1;
    a = W'(av);
    b = W'(bv);
    approx = ap;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout waiting out_valid: got %0d edges, need %0d", lat, W);
    end
    prod = product;
    ef = err_flag;
  endtask

  task automatic deliver(input bit clr, input bit ef);
    out_ready = 1'b1;
    count_clr = clr;
    @(posedge clk); #1;
    out_ready = 1'b0;
    count_clr = 1'b0;
    exp_cnt = model_count(exp_cnt, ef, clr);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    count_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    count_clr = 1'b0;
    exp_cnt = 0;
    vectors++;
    if ({in_ready, out_valid, product, err_flag, viol_count} !== {1'b1, 1'b0, 8'd0, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b vld=%b prod=%0d ef=%b cnt=%0d, need 1 0 0 0 0",
               in_ready, out_valid, product, err_flag, viol_count);
    end
  endtask

  task automatic check_op(input string name, input int av, input int bv, input bit ap, input bit clr);
    int lat;
    logic [2*W-1:0] prod;
    logic ef;
    do_op(av, bv, ap, lat, prod, ef);
    vectors++;
    if (lat !== W) begin
      miscompares++;
      $display("FAIL %s latency: got %0d, need %0d", name, lat, W);
    end
    vectors++;
    if (prod !== 8'(model_prod(av, bv, ap))) begin
      miscompares++;
      $display("FAIL %s product a=%0d b=%0d ap=%b: got %0d, need %0d",
               name, av, bv, ap, prod, model_prod(av, bv, ap));
    end
    vectors++;
    if (ef !== model_err(av, bv, ap)) begin
      miscompares++;
      $display("FAIL %s err_flag a=%0d b=%0d ap=%b: got %b, need %b",
               name, av, bv, ap, ef, model_err(av, bv, ap));
    end
    deliver(clr, model_err(av, bv, ap));
    vectors++;
    if (viol_count !== CW'(exp_cnt) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s after_deliver: cnt=%0d vld=%b rdy=%b, need cnt=%0d vld=0 rdy=1",
               name, viol_count, out_valid, in_ready, exp_cnt);
    end
  endtask

  task automatic test_directed();
    check_op("exact_13x11", 13, 11, 1'b0, 1'b0);
    vectors++;
    if (model_prod(13, 11, 1'b0) != 143 || model_prod(15, 15, 1'b1) != 208 || model_prod(3, 1, 1'b1) != 0) begin
      miscompares++;
      $display("FAIL model_sanity: got %0d %0d %0d, need 143 208 0",
               model_prod(13, 11, 1'b0), model_prod(15, 15, 1'b1), model_prod(3, 1, 1'b1));
    end
    check_op("approx_15x15", 15, 15, 1'b1, 1'b0);
    check_op("approx_3x1", 3, 1, 1'b1, 1'b0);
  endtask

  task automatic test_hold();
    int lat;
    logic [2*W-1:0] prod;
    logic ef;
    do_op(15, 15, 1'b1, lat, prod, ef);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      a = W'($urandom);
      b = W'($urandom);
      approx = 1'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (product !== 8'd208 || err_flag !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL hold cycle %0d: prod=%0d ef=%b rdy=%b vld=%b, need 208 1 0 1",
                 k, product, err_flag, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    deliver(1'b0, 1'b1);
    vectors++;
    if (viol_count !== CW'(exp_cnt) || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: cnt=%0d vld=%b, need cnt=%0d vld=0", viol_count, out_valid, exp_cnt);
    end
  endtask

  task automatic test_saturate();
    int lat;
    logic [2*W-1:0] prod;
    logic ef;
    while (exp_cnt < 255) begin
      do_op(15, 15, 1'b1, lat, prod, ef);
      deliver(1'b0, 1'b1);
    end
    vectors++;
    if (viol_count !== 8'd255) begin
      miscompares++;
      $display("FAIL preset_255: got %0d, need 255", viol_count);
    end
    check_op("saturate", 15, 15, 1'b1, 1'b0);
    check_op("clr_with_viol", 15, 15, 1'b1, 1'b1);
  endtask

  task automatic test_rst_run();
    check_op("pre_rst", 7, 9, 1'b1, 1'b0);
    in_valid = 1'b1;
    a = 4'd12;
    b = 4'd13;
    approx = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    vectors++;
    if ({in_ready, out_valid, product, err_flag, viol_count} !== {1'b1, 1'b0, 8'd0, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL rst_in_run: rdy=%b vld=%b prod=%0d ef=%b cnt=%0d, need 1 0 0 0 0",
               in_ready, out_valid, product, err_flag, viol_count);
    end
    check_op("after_rst_2x3", 2, 3, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int av = int'($urandom_range(0, 15));
      int bv = int'($urandom_range(0, 15));
      bit ap = 1'($urandom);
      bit clr = ($urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      check_op("random", av, bv, ap, clr);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_hold();
    test_rst_run();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
